// File: rtl/la_dsync_hsctrl.sv
// Source side of a toggle-handshake CDC: holds each accepted word on data_out_o,
// toggles req_out_o, then waits for the synchronized ack toggle to match.

module la_dsync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic in_i,
    output logic out_o
);
    // Deliberately unreset so the chain never sees a reset-induced edge.
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[STAGES-2:0], in_i};
    end

    assign out_o = sync_q[STAGES-1];
endmodule

// state  | meaning
// S_INIT | flushing ack chain, waiting for both sides to agree on the toggle level
// S_IDLE | ready to accept a word
// S_WAIT | request toggled, waiting for matching ack toggle
// S_ERR  | handshake timed out, waiting for clr_err_i
module la_dsync_hsctrl #(
    parameter int DW      = 32,
    parameter int STAGES  = 2,
    parameter int TIMEOUT = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          req_out_o,
    output logic [DW-1:0] data_out_o,
    input  logic          ack_in_i,
    output logic          done_o,
    output logic          busy_o,
    output logic          timeout_err_o,
    input  logic          clr_err_i
);
    localparam int FW = $clog2(STAGES + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] FLUSH_N  = FW'(STAGES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = '1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_ERR} state_t;

    state_t        state_q;
    logic [FW-1:0] flush_q;
    logic [TW-1:0] tmo_q;
    logic          req_q;
    logic [DW-1:0] data_q;
    logic          done_q;
    logic          terr_q;
    logic          ack_s;

    la_dsync #(.STAGES(STAGES)) u_ack_sync (
        .clk_i (clk_i),
        .in_i  (ack_in_i),
        .out_o (ack_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            flush_q <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    if (flush_q != FLUSH_N) flush_q <= flush_q + FW'(1);
                    if ((flush_q == FLUSH_N) && (ack_s == req_q)) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (in_valid_i) begin
                        data_q  <= in_data_i;
                        req_q   <= ~req_q;
                        tmo_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tmo_q != TMO_MAX) tmo_q <= tmo_q + TW'(1);
                    // Completion wins over a timeout landing on the same edge.
                    if (ack_s == req_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if ((TIMEOUT > 0) && (tmo_q == TMO_LAST)) begin
                        terr_q  <= 1'b1;
                        state_q <= S_ERR;
                    end
                end
                S_ERR: begin
                    if (clr_err_i) begin
                        terr_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign in_ready_o    = (state_q == S_IDLE) & ~rst_i;
    assign busy_o        = (state_q != S_IDLE);
    assign req_out_o     = req_q;
    assign data_out_o    = data_q;
    assign done_o        = done_q;
    assign timeout_err_o = terr_q;
endmodule

// File: tb/tb_la_dsync_hsctrl.sv
// Directed + randomized bench for la_dsync_hsctrl; expectations come from a
// transaction-level model of the toggle handshake and its fixed latencies.
module tb_la_dsync_hsctrl;
    localparam int DW      = 32;
    localparam int STAGES  = 2;
    localparam int TIMEOUT = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;
    logic          req_out_o;
    logic [DW-1:0] data_out_o;
    logic          ack_in_i;
    logic          done_o;
    logic          busy_o;
    logic          timeout_err_o;
    logic          clr_err_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: request level, held word, and words awaiting completion.
    logic          exp_req  = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] sb_q[$];

    always #5 clk_i = ~clk_i;

    la_dsync_hsctrl #(.DW(DW), .STAGES(STAGES), .TIMEOUT(TIMEOUT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .req_out_o     (req_out_o),
        .data_out_o    (data_out_o),
        .ack_in_i      (ack_in_i),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .timeout_err_o (timeout_err_o),
        .clr_err_i     (clr_err_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic e_ready, input logic e_busy,
                             input logic e_done, input logic e_terr);
        chk({tag, ".in_ready"}, DW'(in_ready_o), DW'(e_ready));
        chk({tag, ".busy"},     DW'(busy_o),     DW'(e_busy));
        chk({tag, ".done"},     DW'(done_o),     DW'(e_done));
        chk({tag, ".terr"},     DW'(timeout_err_o), DW'(e_terr));
        chk({tag, ".req"},      DW'(req_out_o),  DW'(exp_req));
        chk({tag, ".data"},     data_out_o,      exp_data);
    endtask

    // Ack is returned d cycles after the accept edge; the ack change is then
    // seen by the controller STAGES+1 edges later, which is when done pulses.
    task automatic xfer(input string tag, input logic [DW-1:0] word, input int d,
                        input logic keep_valid);
        chk({tag, ".ready_pre"}, DW'(in_ready_o), DW'(1'b1));
        in_valid_i = 1'b1;
        in_data_i  = word;
        sb_q.push_back(word);
        tick();
        exp_req    = ~exp_req;
        exp_data   = word;
        in_valid_i = keep_valid;
        in_data_i  = $urandom();
        chk_state({tag, ".accept"}, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < d; i++) begin
            tick();
            in_data_i = $urandom();
            chk_state({tag, ".wait"}, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        ack_in_i = exp_req;
        for (int i = 0; i < STAGES; i++) begin
            tick();
            chk_state({tag, ".sync"}, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk_state({tag, ".done"}, 1'b1, 1'b0, 1'b1, 1'b0);
        chk({tag, ".order"}, data_out_o, sb_q.pop_front());
    endtask

    initial begin
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        ack_in_i   = 1'b0;
        clr_err_i  = 1'b0;

        // Reset and flush.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        rst_i = 1'b0;
        chk_state("flush0", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= STAGES; i++) begin
            tick();
            chk_state("flush", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk_state("flush_end", 1'b1, 1'b0, 1'b0, 1'b0);

        // Single transfer.
        xfer("single", 32'hA5A5_0001, 4, 1'b0);
        tick();
        chk_state("single_post", 1'b1, 1'b0, 1'b0, 1'b0);

        // Stream of 8 words with random ack delay.
        for (int k = 0; k < 8; k++) begin
            xfer("stream", DW'($urandom()), int'($urandom_range(1, 10)), 1'b1);
        end
        in_valid_i = 1'b0;
        tick();
        chk_state("stream_post", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stream_sb_empty", DW'(sb_q.size()), DW'(0));

        // Timeout, with clr_err pulsed during WAIT (must be ignored there).
        in_valid_i = 1'b1;
        in_data_i  = 32'h0BAD_CAFE;
        tick();
        in_valid_i = 1'b0;
        exp_req  = ~exp_req;
        exp_data = 32'h0BAD_CAFE;
        chk_state("tmo_accept", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) begin
            clr_err_i = (i >= 5 && i <= 7);
            tick();
            chk_state("tmo_wait", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        clr_err_i = 1'b0;
        tick();
        chk_state("tmo_hit", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("tmo_err_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk_state("tmo_clr", 1'b1, 1'b0, 1'b0, 1'b0);
        ack_in_i = exp_req;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_state("tmo_late_ack", 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Race: ack seen on the same edge the timeout would fire.
        xfer("race", 32'h1234_5678, TIMEOUT - STAGES - 1, 1'b0);
        tick();
        chk_state("race_post", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-WAIT with request high and far side stuck at 1.
        if (exp_req) begin
            xfer("align", 32'h0000_00AA, 2, 1'b0);
            tick();
        end
        in_valid_i = 1'b1;
        in_data_i  = 32'hDEAD_0001;
        tick();
        in_valid_i = 1'b0;
        exp_req  = 1'b1;
        exp_data = 32'hDEAD_0001;
        chk_state("mid_accept", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        rst_i    = 1'b1;
        ack_in_i = 1'b1;
        tick();
        exp_req  = 1'b0;
        exp_data = '0;
        chk_state("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_state("mid_stuck", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        ack_in_i = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            tick();
            chk_state("mid_sync", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk_state("mid_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        xfer("final", 32'hC0DE_0002, 3, 1'b0);
        tick();
        chk_state("final_post", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
